// File: rtl/spi_master_ctl.sv
// Register-mapped SPI master: byte transfers with selectable CPOL/CPHA/bit order,
// programmable prescaler, a one-deep TX holding register and status/interrupt flags.
module spi_master_ctl #(
  parameter int         NUM_CS     = 4,
  parameter logic [7:0] RESET_DIV  = 8'd0,
  parameter logic [1:0] RESET_MODE = 2'b00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        AD,
  input  logic [7:0]        DI,
  output logic [7:0]        DO,
  input  logic              rw,
  input  logic              cs,
  output logic              irq,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] ss_n
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_r;
  logic              cpol_r, cpha_r, lsbf_r, ie_r;
  logic [7:0]        presc_r;
  logic              cpol_l_r, cpha_l_r, lsbf_l_r;
  logic [7:0]        presc_l_r;
  logic [7:0]        tx_sh_r, rx_sh_r, hold_r, rx_r;
  logic [7:0]        div_cnt_r;
  logic [3:0]        edge_cnt_r;
  logic              sck_r, mosi_r, irq_r;
  logic [NUM_CS-1:0] ss_n_r;
  logic              pend_r, rxv_r, ovr_r, wcol_r;
  logic [7:0]        do_r;

  logic       wr_s, rd_s, data_wr_s, data_rd_s, cfg_wr_s, sts_wr_s;
  logic       busy_s, done_s, rdy_s;
  logic       start_s;
  logic [7:0] start_data_s;
  logic       pend_set_s, wcol_set_s;
  logic       pend_nx_s, rxv_nx_s, ovr_nx_s, wcol_nx_s, ie_nx_s;
  logic       sample_s, drive_s;
  logic [7:0] ss_rd_s, rd_data_s;

  function automatic logic out_bit(input logic [7:0] d, input logic lsbf);
    return lsbf ? d[0] : d[7];
  endfunction

  function automatic logic [7:0] shift_out(input logic [7:0] d, input logic lsbf);
    return lsbf ? {1'b1, d[7:1]} : {d[6:0], 1'b1};
  endfunction

  function automatic logic [7:0] shift_in(input logic [7:0] d, input logic b, input logic lsbf);
    return lsbf ? {b, d[7:1]} : {d[6:0], b};
  endfunction

  assign DO   = do_r;
  assign irq  = irq_r;
  assign sck  = sck_r;
  assign mosi = mosi_r;
  assign ss_n = ss_n_r;

  // Bus decode and transfer-start selection
  always_comb begin
    wr_s      = cs & ~rw;
    rd_s      = cs & rw;
    data_wr_s = wr_s & (AD == 3'd1);
    data_rd_s = rd_s & (AD == 3'd1);
    cfg_wr_s  = wr_s & (AD == 3'd0);
    sts_wr_s  = wr_s & (AD == 3'd4);
    busy_s    = (state_r != ST_IDLE);
    done_s    = (state_r == ST_DONE);
    rdy_s     = ~busy_s & ~pend_r;
    start_s      = 1'b0;
    start_data_s = DI;
    case (state_r)
      ST_IDLE: start_s = data_wr_s;
      ST_DONE: begin
        // A write landing in DONE with nothing pending goes straight to the shifter
        if (pend_r) begin
          start_s      = 1'b1;
          start_data_s = hold_r;
        end else begin
          start_s = data_wr_s;
        end
      end
      default: start_s = 1'b0;
    endcase
  end

  // Next values of the status flags and interrupt enable
  always_comb begin
    pend_set_s = data_wr_s & busy_s & ~pend_r & ~done_s;
    wcol_set_s = data_wr_s & pend_r;
    if (done_s & pend_r) begin
      pend_nx_s = 1'b0;
    end else if (pend_set_s) begin
      pend_nx_s = 1'b1;
    end else begin
      pend_nx_s = pend_r;
    end
    if (done_s) begin
      rxv_nx_s = 1'b1;
    end else if (data_rd_s) begin
      rxv_nx_s = 1'b0;
    end else begin
      rxv_nx_s = rxv_r;
    end
    if (done_s & rxv_r & ~data_rd_s) begin
      ovr_nx_s = 1'b1;
    end else if (sts_wr_s & DI[2]) begin
      ovr_nx_s = 1'b0;
    end else begin
      ovr_nx_s = ovr_r;
    end
    if (wcol_set_s) begin
      wcol_nx_s = 1'b1;
    end else if (sts_wr_s & DI[3]) begin
      wcol_nx_s = 1'b0;
    end else begin
      wcol_nx_s = wcol_r;
    end
    if (cfg_wr_s) begin
      ie_nx_s = DI[3];
    end else begin
      ie_nx_s = ie_r;
    end
  end

  // Edge-phase decode: sampling on odd edges for CPHA=0, even edges for CPHA=1
  always_comb begin
    sample_s = (edge_cnt_r[0] == cpha_l_r);
    drive_s  = (edge_cnt_r[0] != cpha_l_r) & (edge_cnt_r != 4'd15);
  end

  // Read-data multiplexer
  always_comb begin
    ss_rd_s             = 8'h00;
    ss_rd_s[NUM_CS-1:0] = ~ss_n_r;
    case (AD)
      3'd0:    rd_data_s = {rdy_s, 3'b000, ie_r, lsbf_r, cpol_r, cpha_r};
      3'd1:    rd_data_s = rx_r;
      3'd2:    rd_data_s = presc_r;
      3'd3:    rd_data_s = ss_rd_s;
      3'd4:    rd_data_s = {4'b0000, wcol_r, ovr_r, rxv_r, busy_s};
      default: rd_data_s = 8'h00;
    endcase
  end

  // Register file, status flags, read data and interrupt output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpol_r <= RESET_MODE[1];
      cpha_r <= RESET_MODE[0];
      lsbf_r <= 1'b0;
      ie_r   <= 1'b0;
      presc_r <= RESET_DIV;
      ss_n_r <= {NUM_CS{1'b1}};
      hold_r <= 8'hFF;
      rx_r   <= 8'hFF;
      pend_r <= 1'b0;
      rxv_r  <= 1'b0;
      ovr_r  <= 1'b0;
      wcol_r <= 1'b0;
      irq_r  <= 1'b0;
      do_r   <= 8'h00;
    end else begin
      if (cfg_wr_s) begin
        cpha_r <= DI[0];
        cpol_r <= DI[1];
        lsbf_r <= DI[2];
      end
      if (wr_s & (AD == 3'd2)) begin
        presc_r <= DI;
      end
      if (wr_s & (AD == 3'd3)) begin
        ss_n_r <= ~DI[NUM_CS-1:0];
      end
      if (pend_set_s) begin
        hold_r <= DI;
      end
      if (done_s) begin
        rx_r <= rx_sh_r;
      end
      if (rd_s) begin
        do_r <= rd_data_s;
      end
      ie_r   <= ie_nx_s;
      pend_r <= pend_nx_s;
      rxv_r  <= rxv_nx_s;
      ovr_r  <= ovr_nx_s;
      wcol_r <= wcol_nx_s;
      irq_r  <= ie_nx_s & (rxv_nx_s | wcol_nx_s);
    end
  end

  // Transfer FSM with shift datapath and registered sck/mosi
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      cpol_l_r   <= RESET_MODE[1];
      cpha_l_r   <= RESET_MODE[0];
      lsbf_l_r   <= 1'b0;
      presc_l_r  <= RESET_DIV;
      tx_sh_r    <= 8'hFF;
      rx_sh_r    <= 8'hFF;
      div_cnt_r  <= 8'd0;
      edge_cnt_r <= 4'd0;
      sck_r      <= RESET_MODE[1];
      mosi_r     <= 1'b1;
    end else if (start_s) begin
      // Mode, bit order and prescaler are frozen for the whole transfer
      state_r    <= ST_SHIFT;
      cpol_l_r   <= cpol_r;
      cpha_l_r   <= cpha_r;
      lsbf_l_r   <= lsbf_r;
      presc_l_r  <= presc_r;
      div_cnt_r  <= 8'd0;
      edge_cnt_r <= 4'd0;
      sck_r      <= cpol_r;
      if (cpha_r) begin
        mosi_r  <= 1'b1;
        tx_sh_r <= start_data_s;
      end else begin
        mosi_r  <= out_bit(start_data_s, lsbf_r);
        tx_sh_r <= shift_out(start_data_s, lsbf_r);
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          sck_r  <= cpol_r;
          mosi_r <= 1'b1;
        end
        ST_SHIFT: begin
          if (div_cnt_r == presc_l_r) begin
            div_cnt_r <= 8'd0;
            sck_r     <= ~sck_r;
            if (sample_s) begin
              rx_sh_r <= shift_in(rx_sh_r, miso, lsbf_l_r);
            end
            if (drive_s) begin
              mosi_r  <= out_bit(tx_sh_r, lsbf_l_r);
              tx_sh_r <= shift_out(tx_sh_r, lsbf_l_r);
            end
            if (edge_cnt_r == 4'd15) begin
              state_r <= ST_DONE;
            end else begin
              edge_cnt_r <= edge_cnt_r + 4'd1;
            end
          end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          sck_r   <= cpol_r;
          mosi_r  <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctl.sv
// Directed bench for spi_master_ctl: reads are scored through an expected-value
// queue drained by a bus monitor; SPI pins are checked directly against hand values.
module tb_spi_master_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] AD = 3'd0;
  logic [7:0] DI = 8'h00;
  logic [7:0] DO;
  logic       rw = 1'b0;
  logic       cs = 1'b0;
  logic       irq, sck, mosi, miso;
  logic [3:0] ss_n;
  logic       miso_val = 1'b0;
  logic       loop = 1'b0;

  int          n_vec = 0;
  int          n_err = 0;
  int          sck_cnt = 0;
  int          c0;
  logic [15:0] mosi_cap = 16'h0000;
  logic [7:0]  exp_val_q[$];
  string       exp_name_q[$];

  assign miso = loop ? mosi : miso_val;

  spi_master_ctl #(.NUM_CS(4), .RESET_DIV(8'd0), .RESET_MODE(2'b00)) dut (
    .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
    .irq(irq), .sck(sck), .mosi(mosi), .miso(miso), .ss_n(ss_n)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // SPI-side capture: mosi as seen on each rising sck
  always @(posedge sck) begin
    sck_cnt++;
    mosi_cap = {mosi_cap[14:0], mosi};
  end

  // Scoreboard monitor: every sampled read is compared with the queued expectation
  always @(posedge clk) begin
    if (cs === 1'b1 && rw === 1'b1) begin
      @(negedge clk);
      if (exp_val_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_unexpected: got %h, nothing expected", DO);
      end else begin
        check(exp_name_q.pop_front(), {8'h00, DO}, {8'h00, exp_val_q.pop_front()});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] e, input string name);
    exp_val_q.push_back(e);
    exp_name_q.push_back(name);
    cs = 1'b1; rw = 1'b1; AD = a;
    @(negedge clk);
    cs = 1'b0; rw = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b0;
    #1;
    check("rst_sck", {15'd0, sck}, 16'd0);
    check("rst_mosi", {15'd0, mosi}, 16'd1);
    check("rst_ss_n", {12'd0, ss_n}, 16'h000F);
    check("rst_irq", {15'd0, irq}, 16'd0);
    check("rst_do", {8'd0, DO}, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(1);
    rd(3'd0, 8'h80, "rst_cfg");
    rd(3'd1, 8'hFF, "rst_rx");
    rd(3'd4, 8'h00, "rst_status");
    rd(3'd2, 8'h00, "rst_presc");
    rd(3'd7, 8'h00, "unused_addr");

    // Mode 0, PRESC=0, loopback A5
    wr(3'd3, 8'hF1);
    idle(1);
    check("ss_n_sel", {12'd0, ss_n}, 16'h000E);
    rd(3'd3, 8'h01, "ss_rd_mask");
    loop = 1'b1;
    c0 = sck_cnt;
    wr(3'd1, 8'hA5);
    idle(16);
    rd(3'd4, 8'h01, "t1_busy_in_done");
    rd(3'd4, 8'h02, "t1_rxv_edge18");
    rd(3'd1, 8'hA5, "t1_rx");
    rd(3'd4, 8'h00, "t1_rxv_clr");
    rd(3'd0, 8'h80, "t1_rdy");
    check("t1_sck_pulses", 16'(sck_cnt - c0), 16'd8);
    check("t1_mosi_bits", {8'd0, mosi_cap[7:0]}, 16'h00A5);

    // Mode 3, PRESC=3, LSB first, send 01 with miso low
    loop = 1'b0;
    miso_val = 1'b0;
    wr(3'd0, 8'h07);
    wr(3'd2, 8'h03);
    idle(1);
    check("t2_sck_idle_hi", {15'd0, sck}, 16'd1);
    rd(3'd0, 8'h87, "t2_cfg");
    c0 = sck_cnt;
    wr(3'd1, 8'h01);
    idle(63);
    rd(3'd4, 8'h01, "t2_busy_edge64");
    rd(3'd4, 8'h01, "t2_done_cycle");
    rd(3'd4, 8'h02, "t2_rxv_edge66");
    rd(3'd1, 8'h00, "t2_rx");
    check("t2_sck_pulses", 16'(sck_cnt - c0), 16'd8);
    check("t2_mosi_bits", {8'd0, mosi_cap[7:0]}, 16'h0080);
    check("t2_mosi_idle", {15'd0, mosi}, 16'd1);
    check("t2_sck_end_hi", {15'd0, sck}, 16'd1);

    // Back-to-back writes, WCOL, irq, OVR
    wr(3'd0, 8'h08);
    wr(3'd2, 8'h00);
    loop = 1'b1;
    c0 = sck_cnt;
    wr(3'd1, 8'h11);
    wr(3'd1, 8'h22);
    wr(3'd1, 8'h33);
    check("t3_irq_wcol", {15'd0, irq}, 16'd1);
    rd(3'd4, 8'h09, "t3_wcol");
    rd(3'd0, 8'h08, "t3_cfg_busy");
    wr(3'd4, 8'h08);
    check("t3_irq_clr", {15'd0, irq}, 16'd0);
    rd(3'd4, 8'h01, "t3_wcol_clr");
    idle(28);
    rd(3'd4, 8'h06, "t3_ovr");
    check("t3_irq_rxv", {15'd0, irq}, 16'd1);
    rd(3'd1, 8'h22, "t3_rx2");
    rd(3'd4, 8'h04, "t3_ovr_held");
    wr(3'd4, 8'h04);
    rd(3'd4, 8'h00, "t3_ovr_clr");
    check("t3_sck_pulses", 16'(sck_cnt - c0), 16'd16);
    check("t3_mosi_bits", mosi_cap, 16'h1122);

    // DATA read coinciding with DONE while RXV is already set
    wr(3'd1, 8'h5A);
    wr(3'd1, 8'hC3);
    idle(32);
    rd(3'd1, 8'h5A, "t4_rx_at_done");
    rd(3'd4, 8'h02, "t4_rxv_set_wins");
    rd(3'd1, 8'hC3, "t4_rx2");
    rd(3'd4, 8'h00, "t4_status");

    // Reset at half-period 7 of a PRESC=3 transfer
    wr(3'd2, 8'h03);
    wr(3'd1, 8'hC3);
    rd(3'd0, 8'h08, "t5_cfg_busy");
    wr(3'd1, 8'h44);
    wr(3'd1, 8'h55);
    rd(3'd4, 8'h09, "t5_wcol");
    idle(21);
    check("t5_mosi_pre", {15'd0, mosi}, 16'd0);
    check("t5_irq_pre", {15'd0, irq}, 16'd1);
    rst = 1'b0;
    #1;
    check("t5_sck_rst", {15'd0, sck}, 16'd0);
    check("t5_mosi_rst", {15'd0, mosi}, 16'd1);
    check("t5_ss_n_rst", {12'd0, ss_n}, 16'h000F);
    check("t5_irq_rst", {15'd0, irq}, 16'd0);
    check("t5_do_rst", {8'd0, DO}, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(1);
    rd(3'd4, 8'h00, "t5_status_rst");
    rd(3'd1, 8'hFF, "t5_rx_rst");
    rd(3'd0, 8'h80, "t5_cfg_rst");
    rd(3'd2, 8'h00, "t5_presc_rst");
    rd(3'd3, 8'h00, "t5_ss_rst");
    wr(3'd3, 8'h01);
    wr(3'd1, 8'h96);
    idle(17);
    rd(3'd4, 8'h02, "t5_rxv_new");
    rd(3'd1, 8'h96, "t5_rx_new");

    idle(3);
    check("sb_drained", 16'(exp_val_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_master_ctl.md
SPI_MASTER_CTL -- requirements
Module: spi_master_ctl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: one clock; reset is asynchronous and active-low.
REQ-002 Parameter NUM_CS, default 4, range 1..8: number of SPI slave-select outputs.
REQ-003 Parameter RESET_DIV, default 8'd0: prescaler value loaded at reset.
REQ-004 Parameter RESET_MODE, default 2'b00: {CPOL,CPHA} loaded at reset.
REQ-005 Port clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous reset, asserted when low.
REQ-007 Port AD, input, 3 bits: register address.
REQ-008 Port DI, input, 8 bits: write data.
REQ-009 Port DO, output, 8 bits: registered read data.
REQ-010 Port rw, input, 1 bit: 1 = read, 0 = write.
REQ-011 Port cs, input, 1 bit: access strobe; each clk cycle with cs=1 is one access.
REQ-012 Port irq, output, 1 bit: IE & (RXV | WCOL).
REQ-013 Port sck, output, 1 bit: SPI clock.
REQ-014 Port mosi, output, 1 bit: SPI data out.
REQ-015 Port miso, input, 1 bit: SPI data in.
REQ-016 Port ss_n, output, NUM_CS bits: active-low slave selects, equal to ~SS[NUM_CS-1:0].

Function
REQ-017 Register map:
- $0 CONFIG RW = {RDY(R), 3'b0, IE, LSBF, CPOL, CPHA}.
- $1 DATA: write queues TX; read returns RX.
- $2 PRESC RW.
- $3 SS RW: bits above NUM_CS read 0.
- $4 STATUS = {4'b0, WCOL, OVR, RXV, BUSY}; write 1 to bit 2 or bit 3 clears that bit.
- Unused addresses read 8'h00 and ignore writes.
REQ-018 A read updates DO on the clk edge that samples cs&rw; DO holds its value otherwise.
REQ-019 RDY = ~BUSY & ~PEND, where PEND flags a loaded one-deep TX holding register.
REQ-020 FSM states:
- IDLE: sck = CPOL.
- SHIFT: 16 half-periods of (PRESC+1) clk cycles each.
- DONE: one cycle.
REQ-021 A DATA write in IDLE loads the shift register; SHIFT starts on the next cycle and BUSY=1.
REQ-022 A DATA write while BUSY with PEND=0 loads the holding register and sets PEND.
REQ-023 A DATA write while PEND=1 is dropped and sets WCOL.
REQ-024 sck toggles at the end of each half-period.
- CPHA=0: MSB (or LSB when LSBF=1) is on mosi at SHIFT entry; miso is sampled on odd edges; mosi shifts on even edges.
- CPHA=1: mosi shifts on odd edges; miso is sampled on even edges.
REQ-025 In DONE the received byte is written to RX.
- If RXV was already 1, OVR is set and RX is still overwritten.
- RXV is set in either case.
REQ-026 After DONE: if PEND=1, the holding byte moves to the shift register, PEND clears and SHIFT re-enters on the next cycle; otherwise the FSM goes to IDLE and BUSY clears.
REQ-027 mosi SHALL be 1 in IDLE.
REQ-028 A DATA read clears RXV in the same cycle.
- If the same cycle is DONE, set wins: RXV stays 1 and OVR is not set.
REQ-029 CONFIG and PRESC writes during SHIFT take effect only at the next SHIFT entry, because SHIFT uses values latched at entry.
REQ-030 SS writes take effect immediately, including mid-transfer.
REQ-031 Each transfer lasts 16*(PRESC+1) cycles in SHIFT; RXV is visible 16*(PRESC+1)+2 edges after the write edge.

Reset
REQ-032 While rst=0:
- State = IDLE; sck = RESET_MODE[1]; mosi = 1; ss_n = all 1s; irq = 0; DO = 8'h00.
- RX = 8'hFF; TX = 8'hFF; PEND, RXV, OVR, WCOL, IE, LSBF = 0; PRESC = RESET_DIV; {CPOL,CPHA} = RESET_MODE.
REQ-033 Reset asserted mid-transfer SHALL abort it immediately with no RX update; after release the block is idle and waits for a new DATA write.

Verification
REQ-034 Mode 0, PRESC=0, SS=8'h01, write DATA=8'hA5 with miso looped to mosi -> ss_n=4'b1110; 8 sck pulses with mosi MSB-first 1,0,1,0,0,1,0,1; RX=8'hA5 and RXV=1 at edge 18; BUSY=0.
REQ-035 Mode 3, PRESC=3, LSBF=1, write 8'h01, miso held 0 -> sck idles high; mosi is 1 for the first bit period only; transfer lasts 64 cycles; RX=8'h00.
REQ-036 Back-to-back writes 8'h11, 8'h22, 8'h33 while busy -> 8'h11 and 8'h22 are sent with a 1-cycle DONE gap; WCOL=1; irq=1 when IE=1; writing 8'h08 to STATUS clears WCOL.
REQ-037 Two transfers with no intervening DATA read -> OVR=1 and RX holds the second byte; a DATA read coinciding with a DONE leaves RXV=1 and OVR unchanged.
REQ-038 rst pulled low at half-period 7 of a transfer -> all outputs at reset values asynchronously; RX=8'hFF; a new write after release completes normally.
